multicycle_control: RTL

- Main control FSM of the multicycle CPU; sits directly upstream of the program counter.
- Decodes the latched instruction opcode and sequences fetch/decode/execute/memory/writeback.
- Drives PCWrite, PCWriteCond and PCSource to the program counter and its PC-source mux, plus all datapath selects and enables.
- Handles memory wait states through a ready handshake.

---
 rtl/multicycle_control.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU: sequences fetch/decode/execute/memory/writeback
// and drives the program-counter load controls plus all datapath selects and enables.
module multicycle_control #(
  parameter int          CNT_WIDTH = 32,
  parameter logic [5:0]  OP_RTYPE  = 6'h00,
  parameter logic [5:0]  OP_LW     = 6'h23,
  parameter logic [5:0]  OP_SW     = 6'h2B,
  parameter logic [5:0]  OP_BEQ    = 6'h04,
  parameter logic [5:0]  OP_J      = 6'h02,
  parameter logic [5:0]  OP_ADDI   = 6'h08
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic [1:0]           PCSource,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [3:0]           state,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC_R  = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDI_EX = 4'd10,
    ADDI_WB = 4'd11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t cur_state, next_state;
  logic   set_illegal;
  logic   retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state   <= FETCH;
      illegal_op  <= 1'b0;
      instr_count <= '0;
    end else begin
      cur_state <= next_state;
      if (set_illegal)
        illegal_op <= 1'b1;
      if (retire)
        instr_count <= instr_count + CNT_ONE;
    end
  end

  assign state = cur_state;

  always_comb begin
    next_state  = FETCH;
    set_illegal = 1'b0;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (cur_state)
      FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) next_state = MEMADR;
        else if (opcode == OP_RTYPE)            next_state = EXEC_R;
        else if (opcode == OP_BEQ)              next_state = BRANCH;
        else if (opcode == OP_J)                next_state = JUMP;
        else if (opcode == OP_ADDI)             next_state = ADDI_EX;
        else begin
          next_state  = FETCH;
          set_illegal = 1'b1;
        end
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        next_state = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        retire     = mem_ready;
        next_state = mem_ready ? FETCH : MEMWR;
      end
      EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        next_state = RWB;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
      ADDI_EX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = ADDI_WB;
      end
      ADDI_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      default: next_state = FETCH;
    endcase
    // The state register resets to FETCH, so strobes must be masked while reset is held.
    if (!reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = 2'b00;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
    end
  end

endmodule
